// File: rtl/mant_div_if.sv
// Handshake bundle for the mantissa divider: operand request channel and result channel.
interface mant_div_if;
    logic        in_valid;
    logic        in_ready;
    logic [10:0] a;
    logic [10:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [12:0] q;
    logic        sticky;
    logic        err;

    modport master (
        output in_valid,
        output a,
        output b,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  q,
        input  sticky,
        input  err
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  out_ready,
        output in_ready,
        output out_valid,
        output q,
        output sticky,
        output err
    );
endinterface

// File: rtl/mant_div.sv
// Restoring mantissa divider: q = floor(a * 2^12 / b) over 13 iterations, one bit per cycle.
module mant_div (
    input  logic      clk,
    input  logic      rst_n,
    mant_div_if.slave io_bus
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e      r_state;
    state_e      w_state_next;
    logic [11:0] r_rem;
    logic [12:0] r_q;
    logic [3:0]  r_cnt;
    logic [10:0] r_b;
    logic        r_sticky;
    logic        r_err;

    logic        w_in_ready;
    logic        w_out_valid;
    logic        w_accept;
    logic        w_div0;
    logic        w_unnorm;
    logic        w_ge;
    logic [11:0] w_diff;
    logic [11:0] w_rem_next;

    assign w_accept = io_bus.in_valid && (r_state == StIdle);
    assign w_div0   = (io_bus.b == 11'd0);
    assign w_unnorm = !io_bus.a[10] || !io_bus.b[10];

    // Remainder stays below 2*b, so the shifted value always fits in 12 bits.
    assign w_ge       = (r_rem >= {1'b0, r_b});
    assign w_diff     = w_ge ? (r_rem - {1'b0, r_b}) : r_rem;
    assign w_rem_next = (r_cnt == 4'd0) ? w_diff : {w_diff[10:0], 1'b0};

    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        case (r_state)
            StIdle: begin
                w_in_ready = 1'b1;
                if (io_bus.in_valid) begin
                    w_state_next = (w_div0 || w_unnorm) ? StDone : StBusy;
                end
            end
            StBusy: begin
                if (r_cnt == 4'd0) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                w_out_valid = 1'b1;
                if (io_bus.out_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= StIdle;
            r_rem    <= 12'd0;
            r_q      <= 13'd0;
            r_cnt    <= 4'd0;
            r_b      <= 11'd0;
            r_sticky <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_b      <= io_bus.b;
                        r_sticky <= 1'b0;
                        if (w_div0) begin
                            r_q   <= 13'h1FFF;
                            r_err <= 1'b1;
                        end else if (w_unnorm) begin
                            r_q   <= 13'h0000;
                            r_err <= 1'b1;
                        end else begin
                            r_rem <= {1'b0, io_bus.a};
                            r_q   <= 13'h0000;
                            r_cnt <= 4'd12;
                            r_err <= 1'b0;
                        end
                    end
                end
                StBusy: begin
                    r_rem        <= w_rem_next;
                    r_q[r_cnt]   <= w_ge;
                    if (r_cnt == 4'd0) begin
                        r_sticky <= (w_diff != 12'd0);
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign io_bus.in_ready  = w_in_ready;
    assign io_bus.out_valid = w_out_valid;
    assign io_bus.q         = r_q;
    assign io_bus.sticky    = r_sticky;
    assign io_bus.err       = r_err;

endmodule

// File: tb/tb_mant_div.sv
// Directed and randomized self-checking bench for mant_div.
module tb_mant_div;

    localparam int NumRandom = 3000;
    localparam int LatBound  = 40;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_mis;

    mant_div_if bus ();

    mant_div u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #10ms;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transaction; error results are expected in the cycle right after the accept edge.
    task automatic run_op(input string tag, input logic [10:0] ta, input logic [10:0] tb_v,
                          input logic [12:0] eq, input logic es, input logic ee, input int elat,
                          input int gap, input int hold);
        int lat;
        int wt;
        bus.in_valid = 1'b0;
        repeat (gap) step();
        wt = 0;
        while (!bus.in_ready && wt < LatBound) begin
            step();
            wt++;
        end
        check_eq({tag, "_rdy"}, bus.in_ready, 1'b1);
        bus.in_valid = 1'b1;
        bus.a        = ta;
        bus.b        = tb_v;
        step();
        bus.in_valid = 1'b0;
        bus.a        = ~ta;
        bus.b        = ~tb_v;
        lat = 0;
        while (!bus.out_valid && lat < LatBound) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            step();
            lat++;
        end
        bus.out_ready = 1'b0;
        check_eq({tag, "_lat"}, lat, elat);
        check_eq({tag, "_q"}, bus.q, eq);
        check_eq({tag, "_sticky"}, bus.sticky, es);
        check_eq({tag, "_err"}, bus.err, ee);
        repeat (hold) step();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        logic [10:0] ra;
        logic [10:0] rb;
        logic [31:0] num;
        n_cmp         = 0;
        n_mis         = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = 11'd0;
        bus.b         = 11'd0;
        step();
        step();
        check_eq("rst_out_valid", bus.out_valid, 1'b0);
        check_eq("rst_q", bus.q, 13'h0000);
        check_eq("rst_sticky", bus.sticky, 1'b0);
        check_eq("rst_err", bus.err, 1'b0);
        rst_n = 1'b1;
        step();
        check_eq("rst_in_ready", bus.in_ready, 1'b1);

        run_op("unity", 11'h400, 11'h400, 13'h1000, 1'b0, 1'b0, 13, 0, 0);
        run_op("max_q", 11'h7FF, 11'h400, 13'h1FFC, 1'b0, 1'b0, 13, 0, 0);
        run_op("min_q", 11'h400, 11'h7FF, 13'h0801, 1'b1, 1'b0, 13, 1, 2);
        run_op("one_half", 11'h600, 11'h400, 13'h1800, 1'b0, 1'b0, 13, 0, 0);
        run_op("five_sixth", 11'h500, 11'h600, 13'h0D55, 1'b1, 1'b0, 13, 2, 0);
        run_op("div0", 11'h555, 11'h000, 13'h1FFF, 1'b0, 1'b1, 0, 0, 0);
        run_op("div0_zero_a", 11'h000, 11'h000, 13'h1FFF, 1'b0, 1'b1, 0, 0, 1);
        run_op("unnorm_a", 11'h3FF, 11'h600, 13'h0000, 1'b0, 1'b1, 0, 0, 0);
        run_op("unnorm_b", 11'h400, 11'h300, 13'h0000, 1'b0, 1'b1, 0, 0, 0);
        run_op("after_err", 11'h400, 11'h400, 13'h1000, 1'b0, 1'b0, 13, 0, 0);

        // Stall in DONE while the producer keeps offering new operands.
        bus.in_valid = 1'b1;
        bus.a        = 11'h500;
        bus.b        = 11'h600;
        step();
        repeat (13) step();
        check_eq("hold_valid", bus.out_valid, 1'b1);
        for (int i = 0; i < 20; i++) begin
            bus.a = (i % 2 == 0) ? 11'h7FF : 11'h400;
            bus.b = (i % 2 == 0) ? 11'h400 : 11'h000;
            step();
            check_eq("hold_q", bus.q, 13'h0D55);
            check_eq("hold_sticky", bus.sticky, 1'b1);
            check_eq("hold_in_ready", bus.in_ready, 1'b0);
            check_eq("hold_out_valid", bus.out_valid, 1'b1);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check_eq("hold_release_rdy", bus.in_ready, 1'b1);
        check_eq("hold_release_ov", bus.out_valid, 1'b0);
        run_op("post_hold", 11'h400, 11'h7FF, 13'h0801, 1'b1, 1'b0, 13, 0, 0);

        // Reset sampled on the fifth BUSY edge abandons the division.
        bus.in_valid = 1'b1;
        bus.a        = 11'h7FF;
        bus.b        = 11'h400;
        step();
        bus.in_valid = 1'b0;
        repeat (4) step();
        rst_n = 1'b0;
        step();
        check_eq("busy_rst_ov", bus.out_valid, 1'b0);
        check_eq("busy_rst_q", bus.q, 13'h0000);
        rst_n = 1'b1;
        step();
        check_eq("busy_rst_rdy", bus.in_ready, 1'b1);
        repeat (14) step();
        check_eq("busy_rst_no_result", bus.out_valid, 1'b0);
        run_op("post_rst", 11'h600, 11'h600, 13'h1000, 1'b0, 1'b0, 13, 0, 0);

        // Reset wins over an accept on the same edge.
        rst_n        = 1'b0;
        bus.in_valid = 1'b1;
        bus.a        = 11'h400;
        bus.b        = 11'h000;
        step();
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;
        step();
        check_eq("rst_prio_ov", bus.out_valid, 1'b0);
        check_eq("rst_prio_rdy", bus.in_ready, 1'b1);
        check_eq("rst_prio_err", bus.err, 1'b0);

        for (int n = 0; n < NumRandom; n++) begin
            ra  = {1'b1, 10'($urandom)};
            rb  = {1'b1, 10'($urandom)};
            num = {ra, 12'd0};
            run_op("rand", ra, rb, 13'(num / rb), ((num % rb) != 0), 1'b0, 13,
                   $urandom_range(0, 1), $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
